branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_if.sv | 41 ++++
 rtl/branch_predictor.sv | 130 +++++++++++++
 2 files changed

// File: rtl/branch_predictor_if.sv
// Lookup/predict/update/statistics bundle between the fetch front end and the branch predictor.
// The front end takes the master modport; the predictor takes the slave modport.
interface branch_predictor_if #(
  parameter int PC_W  = 32,
  parameter int GHR_W = 4
);
  logic              stall_x70;
  logic              lookup_valid_x70;
  logic [PC_W-1:0]   lookup_pc_x70;
  logic              predict_valid_x70;
  logic              predict_taken_x70;
  logic [GHR_W-1:0]  predict_ghr_x70;
  logic              predict_hit_x70;
  logic [PC_W-1:0]   predict_target_x70;
  logic              update_valid_x70;
  logic [PC_W-1:0]   update_pc_x70;
  logic [GHR_W-1:0]  update_ghr_x70;
  logic              update_taken_x70;
  logic [PC_W-1:0]   update_target_x70;
  logic              update_mispredict_x70;
  logic [15:0]       stat_lookups_x70;
  logic [15:0]       stat_mispredicts_x70;

  modport master (
    output stall_x70, lookup_valid_x70, lookup_pc_x70,
    output update_valid_x70, update_pc_x70, update_ghr_x70,
    output update_taken_x70, update_target_x70, update_mispredict_x70,
    input  predict_valid_x70, predict_taken_x70, predict_ghr_x70,
    input  predict_hit_x70, predict_target_x70,
    input  stat_lookups_x70, stat_mispredicts_x70
  );

  modport slave (
    input  stall_x70, lookup_valid_x70, lookup_pc_x70,
    input  update_valid_x70, update_pc_x70, update_ghr_x70,
    input  update_taken_x70, update_target_x70, update_mispredict_x70,
    output predict_valid_x70, predict_taken_x70, predict_ghr_x70,
    output predict_hit_x70, predict_target_x70,
    output stat_lookups_x70, stat_mispredicts_x70
  );
endinterface

// File: rtl/branch_predictor.sv
// Gshare direction predictor with speculative global history, mispredict repair and statistics.
// Prediction 1 cycle after an accepted lookup; stall freezes lookups. Define BP_BTB_EN for a direct-mapped target buffer.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int GHR_W   = 4,
  parameter int PC_W    = 32
) (
  input  logic               clk_x70,
  input  logic               rst_n_x70,
  branch_predictor_if.slave  bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CTR_W-1:0] ctr_t;

  localparam ctr_t CTR_MAX  = {CTR_W{1'b1}};
  localparam ctr_t CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};

  ctr_t             ctr [ENTRIES];
  logic [GHR_W-1:0] ghr;

  logic             lk_acc;
  logic             repair;
  idx_t             lk_idx;
  idx_t             up_idx;
  logic             lk_taken;
  logic             lk_hit;
  logic [PC_W-1:0]  lk_tgt;
  logic             unused_bits;

  assign lk_acc   = bp.lookup_valid_x70 & ~bp.stall_x70;
  assign repair   = bp.update_valid_x70 & bp.update_mispredict_x70;
  assign lk_idx   = bp.lookup_pc_x70[IDX_W+1:2] ^ idx_t'(ghr);
  assign up_idx   = bp.update_pc_x70[IDX_W+1:2] ^ idx_t'(bp.update_ghr_x70);
  // Lookup reads the array before this cycle's update lands.
  assign lk_taken = ctr[lk_idx][CTR_W-1];

  always_ff @(posedge clk_x70 or negedge rst_n_x70) begin
    if (!rst_n_x70) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_INIT;
    end else if (bp.update_valid_x70) begin
      if (bp.update_taken_x70 && ctr[up_idx] != CTR_MAX)
        ctr[up_idx] <= ctr[up_idx] + ctr_t'(1);
      else if (!bp.update_taken_x70 && ctr[up_idx] != '0)
        ctr[up_idx] <= ctr[up_idx] - ctr_t'(1);
    end
  end

  // Repair from the returned checkpoint wins over the speculative shift.
  always_ff @(posedge clk_x70 or negedge rst_n_x70) begin
    if (!rst_n_x70)
      ghr <= '0;
    else if (repair)
      ghr <= GHR_W'({bp.update_ghr_x70, bp.update_taken_x70});
    else if (lk_acc)
      ghr <= GHR_W'({ghr, lk_taken});
  end

  always_ff @(posedge clk_x70 or negedge rst_n_x70) begin
    if (!rst_n_x70) begin
      bp.predict_valid_x70  <= 1'b0;
      bp.predict_taken_x70  <= 1'b0;
      bp.predict_ghr_x70    <= '0;
      bp.predict_hit_x70    <= 1'b0;
      bp.predict_target_x70 <= '0;
    end else begin
      bp.predict_valid_x70 <= lk_acc;
      if (lk_acc) begin
        bp.predict_taken_x70  <= lk_taken;
        bp.predict_ghr_x70    <= ghr;
        bp.predict_hit_x70    <= lk_hit;
        bp.predict_target_x70 <= lk_tgt;
      end
    end
  end

  always_ff @(posedge clk_x70 or negedge rst_n_x70) begin
    if (!rst_n_x70) begin
      bp.stat_lookups_x70     <= '0;
      bp.stat_mispredicts_x70 <= '0;
    end else begin
      if (lk_acc && bp.stat_lookups_x70 != 16'hFFFF)
        bp.stat_lookups_x70 <= bp.stat_lookups_x70 + 16'd1;
      if (repair && bp.stat_mispredicts_x70 != 16'hFFFF)
        bp.stat_mispredicts_x70 <= bp.stat_mispredicts_x70 + 16'd1;
    end
  end

`ifdef BP_BTB_EN
  logic             btb_vld [ENTRIES];
  logic [TAG_W-1:0] btb_tag [ENTRIES];
  logic [PC_W-1:0]  btb_tgt [ENTRIES];
  idx_t             lk_bidx;
  idx_t             up_bidx;
  logic             btb_wr;

  assign lk_bidx = bp.lookup_pc_x70[IDX_W+1:2];
  assign up_bidx = bp.update_pc_x70[IDX_W+1:2];
  assign btb_wr  = bp.update_valid_x70 & bp.update_taken_x70;
  assign lk_hit  = btb_vld[lk_bidx] && (btb_tag[lk_bidx] == bp.lookup_pc_x70[PC_W-1:IDX_W+2]);
  assign lk_tgt  = lk_hit ? btb_tgt[lk_bidx] : '0;

  always_ff @(posedge clk_x70 or negedge rst_n_x70) begin
    if (!rst_n_x70) begin
      for (int i = 0; i < ENTRIES; i++) btb_vld[i] <= 1'b0;
    end else if (btb_wr) begin
      btb_vld[up_bidx] <= 1'b1;
    end
  end

  // Tag and target are qualified by the valid bit, so they need no reset.
  always_ff @(posedge clk_x70) begin
    if (btb_wr) begin
      btb_tag[up_bidx] <= bp.update_pc_x70[PC_W-1:IDX_W+2];
      btb_tgt[up_bidx] <= bp.update_target_x70;
    end
  end

  assign unused_bits = ^{bp.lookup_pc_x70[1:0], bp.update_pc_x70[1:0]};
`else
  assign lk_hit      = 1'b0;
  assign lk_tgt      = '0;
  assign unused_bits = ^{bp.lookup_pc_x70[1:0], bp.lookup_pc_x70[PC_W-1:IDX_W+2],
                         bp.update_pc_x70[1:0], bp.update_pc_x70[PC_W-1:IDX_W+2],
                         bp.update_target_x70};
`endif
endmodule
